dcpu16_marb: RTL and testbench

- Arbiter sharing one single-port memory between the CPU's two Simplified-Wishbone masters: F-BUS (fetch/write-back) and G-BUS (operand read).
- Sits between the CPU memory-bus unit and the memory.
- One transaction in flight at a time.
- Round-robin on simultaneous requests; a watchdog terminates slaves that never acknowledge.

---
 rtl/dcpu16_pkg.sv | 22 ++
 rtl/dcpu16_wdog.sv | 36 +++
 rtl/dcpu16_marb.sv | 121 ++++++++++++
 tb/tb_dcpu16_marb.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcpu16_pkg.sv
// Shared definitions for the dcpu16 memory arbiter.
//   - default bus widths
//   - arbiter state encodings
//   - master port identifiers for round-robin tracking
//   - read value returned to a master when its memory cycle times out
package dcpu16_pkg;

  localparam int BUS_AW = 16;
  localparam int BUS_DW = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWNF = 2'd1;
  localparam logic [1:0] ST_OWNG = 2'd2;

  localparam logic [15:0] TMO_RD = 16'hFFFF;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_G = 1'b1
  } port_t;

endpackage

// File: rtl/dcpu16_wdog.sv
// Saturating watchdog counter for the memory arbiter.
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   clr    - synchronous clear (held while no transaction is owned)
//   en     - count enable (owned transaction still waiting for m_ack)
//   expire - count has reached TMO; always 0 when TMO == 0
module dcpu16_wdog #(
  parameter int TMO = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TMO);

  logic [CW-1:0] cnt;

  // Stops at LIMIT so a stuck slave can never wrap the count back to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (TMO > 0) && (cnt == LIMIT);

endmodule

// File: rtl/dcpu16_marb.sv
// Arbiter sharing one single-port memory between the F-BUS (fetch /
// write-back) and G-BUS (operand read) Simplified-Wishbone masters.
// One transaction in flight, round-robin on ties, watchdog on the slave.
// Ports:
//   clk, rst                         - clock, asynchronous active-high reset
//   f_adr/f_stb/f_wre/f_dto -> f_dti/f_ack  F-BUS master side
//   g_adr/g_stb/g_wre/g_dto -> g_dti/g_ack  G-BUS master side
//   m_adr/m_stb/m_wre/m_dto <- m_dti/m_ack  memory side
//   m_err                            - one-cycle pulse on watchdog expiry
module dcpu16_marb
  import dcpu16_pkg::*;
#(
  parameter int AW  = BUS_AW,
  parameter int DW  = BUS_DW,
  parameter int TMO = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] f_adr,
  input  logic          f_stb,
  input  logic          f_wre,
  input  logic [DW-1:0] f_dto,
  output logic [DW-1:0] f_dti,
  output logic          f_ack,
  input  logic [AW-1:0] g_adr,
  input  logic          g_stb,
  input  logic          g_wre,
  input  logic [DW-1:0] g_dto,
  output logic [DW-1:0] g_dti,
  output logic          g_ack,
  output logic [AW-1:0] m_adr,
  output logic          m_stb,
  output logic          m_wre,
  output logic [DW-1:0] m_dto,
  input  logic [DW-1:0] m_dti,
  input  logic          m_ack,
  output logic          m_err
);

  logic [1:0]    state;
  port_t         last;
  logic [DW-1:0] f_dti_q;
  logic [DW-1:0] g_dti_q;
  logic          own_f;
  logic          own_g;
  logic          owned;
  logic          expire;
  logic          tmo_hit;
  logic          done;
  logic          pick_g;
  logic [DW-1:0] rsp_dti;

  assign own_f = (state == ST_OWNF);
  assign own_g = (state == ST_OWNG);
  assign owned = own_f | own_g;

  // A real m_ack on the expiry cycle wins over the timeout.
  assign tmo_hit = owned && expire && !m_ack;
  assign done    = owned && (m_ack || expire);
  assign m_err   = tmo_hit;
  assign rsp_dti = tmo_hit ? DW'(TMO_RD) : m_dti;

  // A master that dropped stb mid-cycle gets no ack; the memory cycle
  // still completes so the slave is never abandoned half-way.
  assign f_ack = own_f && f_stb && done;
  assign g_ack = own_g && g_stb && done;
  assign f_dti = own_f ? rsp_dti : f_dti_q;
  assign g_dti = own_g ? rsp_dti : g_dti_q;

  // Tie goes to whichever port was not served last.
  assign pick_g = g_stb && (!f_stb || (last == PORT_F));

  dcpu16_wdog #(
    .TMO(TMO)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (!owned),
    .en    (owned && !m_ack),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      last    <= PORT_G;
      m_adr   <= '0;
      m_stb   <= 1'b0;
      m_wre   <= 1'b0;
      m_dto   <= '0;
      f_dti_q <= '0;
      g_dti_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (f_stb || g_stb) begin
            state <= pick_g ? ST_OWNG : ST_OWNF;
            last  <= pick_g ? PORT_G : PORT_F;
            m_stb <= 1'b1;
            m_adr <= pick_g ? g_adr : f_adr;
            m_wre <= pick_g ? g_wre : f_wre;
            m_dto <= pick_g ? g_dto : f_dto;
          end
        end
        ST_OWNF, ST_OWNG: begin
          if (done) begin
            state <= ST_IDLE;
            m_stb <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          m_stb <= 1'b0;
        end
      endcase
      if (f_ack) f_dti_q <= rsp_dti;
      if (g_ack) g_dti_q <= rsp_dti;
    end
  end

endmodule

// File: tb/tb_dcpu16_marb.sv
// Self-checking bench for dcpu16_marb: directed scenarios plus a randomized
// two-master run checked against a round-robin reference model.
module tb_dcpu16_marb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] f_adr, f_dto, f_dti;
  logic        f_stb, f_wre, f_ack;
  logic [15:0] g_adr, g_dto, g_dti;
  logic        g_stb, g_wre, g_ack;
  logic [15:0] m_adr, m_dto;
  logic        m_stb, m_wre, m_err;
  logic [15:0] m_dti = 16'h0000;
  logic        m_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // memory model controls
  logic [15:0] mem [0:65535];
  int lat = 1;
  int cur_lat = 1;
  int mcnt = 0;
  bit rand_lat = 1'b0;
  bit spur = 1'b0;

  // grant log written by run_masters: 0 = F, 1 = G
  bit own_q[$];
  int rise_q[$];

  dcpu16_marb #(.AW(16), .DW(16), .TMO(15)) dut (
    .clk(clk), .rst(rst),
    .f_adr(f_adr), .f_stb(f_stb), .f_wre(f_wre), .f_dto(f_dto), .f_dti(f_dti), .f_ack(f_ack),
    .g_adr(g_adr), .g_stb(g_stb), .g_wre(g_wre), .g_dto(g_dto), .g_dti(g_dti), .g_ack(g_ack),
    .m_adr(m_adr), .m_stb(m_stb), .m_wre(m_wre), .m_dto(m_dto), .m_dti(m_dti), .m_ack(m_ack),
    .m_err(m_err)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hC35A;
  end

  // Memory: acks in the cycle numbered cur_lat after m_stb rises (0-based);
  // a negative latency never acks.
  always @(posedge clk) begin
    #1;
    m_ack = 1'b0;
    if (m_stb) begin
      if (mcnt == 0) cur_lat = rand_lat ? int'($urandom_range(0, 4)) : lat;
      if (mcnt == cur_lat) begin
        m_ack = 1'b1;
        m_dti = mem[m_adr];
      end
      mcnt++;
    end else begin
      mcnt = 0;
      if (spur) begin
        m_ack = 1'b1;
        m_dti = 16'hDEAD;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; f_stb = 1'b0; g_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic single_txn(input bit use_g, input logic [15:0] adr, input bit wre,
                            input logic [15:0] dto, input int drop_at,
                            output int rise_cyc, output int own_acks, output int oth_acks,
                            output logic [15:0] ack_dti, output int ack_cyc,
                            output int err_cnt, output int err_cyc, output bit stable,
                            output int stb_cyc, output bit fin);
    bit got_ack;
    got_ack = 1'b0; rise_cyc = -1; own_acks = 0; oth_acks = 0; ack_dti = '0;
    ack_cyc = -1; err_cnt = 0; err_cyc = -1; stable = 1'b1; stb_cyc = 0; fin = 1'b0;
    @(posedge clk); #1;
    if (use_g) begin g_adr = adr; g_wre = wre; g_dto = dto; g_stb = 1'b1; end
    else begin f_adr = adr; f_wre = wre; f_dto = dto; f_stb = 1'b1; end
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        if (got_ack || cyc == drop_at) begin f_stb = 1'b0; g_stb = 1'b0; end
      end
      @(negedge clk);
      if (m_stb) begin
        if (rise_cyc < 0) rise_cyc = cyc;
        stb_cyc++;
        if (m_adr !== adr || m_wre !== wre || (wre && m_dto !== dto)) stable = 1'b0;
      end
      if ((use_g ? g_ack : f_ack) === 1'b1) begin
        own_acks++; ack_cyc = cyc; ack_dti = use_g ? g_dti : f_dti; got_ack = 1'b1;
      end
      if ((use_g ? f_ack : g_ack) === 1'b1) oth_acks++;
      if (m_err === 1'b1) begin err_cnt++; err_cyc = cyc; end
      if (rise_cyc >= 0 && !m_stb) begin fin = 1'b1; break; end
    end
    f_stb = 1'b0; g_stb = 1'b0;
  endtask

  // Two masters issuing nf / ng transactions with random gaps; every grant
  // is predicted from the round-robin rule applied to the requests seen.
  task automatic run_masters(input int nf, input int ng, input int max_gap);
    int remf, remg, donef, doneg, gapf, gapg;
    bit ackf, ackg, last_g, prev_rf, prev_rg, prev_stb, cur_g, exp_g, finished;
    own_q.delete(); rise_q.delete();
    remf = nf; remg = ng; donef = 0; doneg = 0; gapf = 0; gapg = 0;
    ackf = 0; ackg = 0; last_g = 1'b1; prev_rf = 0; prev_rg = 0; prev_stb = 0;
    cur_g = 0; finished = 0;
    f_stb = 1'b0; g_stb = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (ackf) begin f_stb = 1'b0; ackf = 0; gapf = int'($urandom_range(0, max_gap)); end
      if (!f_stb && remf > 0) begin
        if (gapf == 0) begin
          f_adr = {1'b0, 15'($urandom)}; f_wre = 1'($urandom); f_dto = 16'($urandom);
          f_stb = 1'b1; remf--;
        end else gapf--;
      end
      if (ackg) begin g_stb = 1'b0; ackg = 0; gapg = int'($urandom_range(0, max_gap)); end
      if (!g_stb && remg > 0) begin
        if (gapg == 0) begin
          g_adr = {1'b1, 15'($urandom)}; g_wre = 1'($urandom); g_dto = 16'($urandom);
          g_stb = 1'b1; remg--;
        end else gapg--;
      end
      @(negedge clk);
      if (m_stb && !prev_stb) begin
        n_cmp++;
        if (!prev_rf && !prev_rg) begin
          n_bad++; $display("FAIL rr_spurious_grant: got m_stb=1 want 0 (no request)");
        end else begin
          exp_g = (prev_rf && prev_rg) ? !last_g : prev_rg;
          if (m_adr[15] !== exp_g) begin
            n_bad++; $display("FAIL rr_grant_owner: got %0d want %0d (0=F 1=G)", m_adr[15], exp_g);
          end
          n_cmp++;
          if (m_adr !== (exp_g ? g_adr : f_adr) || m_wre !== (exp_g ? g_wre : f_wre) ||
              m_dto !== (exp_g ? g_dto : f_dto)) begin
            n_bad++; $display("FAIL rr_grant_payload: got %h/%b/%h want %h/%b/%h", m_adr, m_wre, m_dto,
                              exp_g ? g_adr : f_adr, exp_g ? g_wre : f_wre, exp_g ? g_dto : f_dto);
          end
          last_g = exp_g; cur_g = exp_g;
        end
        own_q.push_back(m_adr[15]); rise_q.push_back(cyc);
      end
      if (!m_stb && !prev_stb && (prev_rf || prev_rg)) begin
        n_cmp++; n_bad++;
        $display("FAIL rr_stall: got m_stb=0 want 1 (request pending in idle)");
      end
      if (f_ack === 1'b1) begin
        n_cmp++;
        if (!(m_stb && !cur_g) || g_ack === 1'b1) begin
          n_bad++; $display("FAIL rr_f_ack_owner: got ack while owner=%0d want F", cur_g);
        end
        if (!f_wre) begin
          n_cmp++;
          if (f_dti !== mem[f_adr]) begin
            n_bad++; $display("FAIL rr_f_rdata: got %h want %h", f_dti, mem[f_adr]);
          end
        end
        ackf = 1; donef++;
      end
      if (g_ack === 1'b1) begin
        n_cmp++;
        if (!(m_stb && cur_g)) begin
          n_bad++; $display("FAIL rr_g_ack_owner: got ack while owner=%0d want G", cur_g);
        end
        if (!g_wre) begin
          n_cmp++;
          if (g_dti !== mem[g_adr]) begin
            n_bad++; $display("FAIL rr_g_rdata: got %h want %h", g_dti, mem[g_adr]);
          end
        end
        ackg = 1; doneg++;
      end
      if (m_err !== 1'b0) begin
        n_cmp++; n_bad++; $display("FAIL rr_m_err: got %b want 0", m_err);
      end
      prev_rf = f_stb; prev_rg = g_stb; prev_stb = m_stb;
      if (donef == nf && doneg == ng && !m_stb) begin finished = 1; break; end
    end
    f_stb = 1'b0; g_stb = 1'b0;
    n_cmp++;
    if (!finished) begin
      n_bad++; $display("FAIL rr_budget: got %0d/%0d done want %0d/%0d", donef, doneg, nf, ng);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (m_stb !== 1'b0) begin n_bad++; $display("FAIL reset_m_stb: got %b want 0", m_stb); end
    n_cmp++; if ({m_adr, m_dto, m_wre} !== 33'd0) begin n_bad++; $display("FAIL reset_m_bus: got %h/%h/%b want 0", m_adr, m_dto, m_wre); end
    n_cmp++; if (m_err !== 1'b0) begin n_bad++; $display("FAIL reset_m_err: got %b want 0", m_err); end
    n_cmp++; if ({f_ack, g_ack} !== 2'b00) begin n_bad++; $display("FAIL reset_acks: got %b%b want 00", f_ack, g_ack); end
    n_cmp++; if ({f_dti, g_dti} !== 32'd0) begin n_bad++; $display("FAIL reset_dti: got %h/%h want 0", f_dti, g_dti); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single_read();
    int r, oa, xa, ac, ec, ecy, sc; logic [15:0] d; bit st, fn;
    mem[16'h0100] = 16'hBEEF; lat = 2;
    single_txn(1'b0, 16'h0100, 1'b0, 16'h0000, -1, r, oa, xa, d, ac, ec, ecy, st, sc, fn);
    n_cmp++; if (r !== 1) begin n_bad++; $display("FAIL read_stb_latency: got %0d want 1", r); end
    n_cmp++; if (!st) begin n_bad++; $display("FAIL read_m_bus: got unstable/wrong want 0100/0"); end
    n_cmp++; if (oa !== 1 || xa !== 0) begin n_bad++; $display("FAIL read_ack_count: got f=%0d g=%0d want 1/0", oa, xa); end
    n_cmp++; if (d !== 16'hBEEF) begin n_bad++; $display("FAIL read_f_dti: got %h want beef", d); end
    n_cmp++; if (ac !== 3 || ec !== 0 || !fn) begin n_bad++; $display("FAIL read_ack_cycle: got %0d err=%0d want 3 err=0", ac, ec); end
    n_cmp++; if (f_dti !== 16'hBEEF) begin n_bad++; $display("FAIL read_f_dti_hold: got %h want beef", f_dti); end
  endtask

  task automatic test_g_write();
    int r, oa, xa, ac, ec, ecy, sc; logic [15:0] d; bit st, fn;
    lat = 1;
    single_txn(1'b1, 16'h8000, 1'b1, 16'h1234, -1, r, oa, xa, d, ac, ec, ecy, st, sc, fn);
    n_cmp++; if (!st || r !== 1) begin n_bad++; $display("FAIL write_m_bus_stable: got stable=%b rise=%0d want 1/1", st, r); end
    n_cmp++; if (oa !== 1 || xa !== 0) begin n_bad++; $display("FAIL write_g_ack: got g=%0d f=%0d want 1/0", oa, xa); end
    n_cmp++; if (sc !== 2 || !fn) begin n_bad++; $display("FAIL write_stb_len: got %0d want 2", sc); end
    n_cmp++; if (f_dti !== 16'hBEEF) begin n_bad++; $display("FAIL write_f_dti_hold: got %h want beef", f_dti); end
  endtask

  task automatic test_watchdog();
    int r, oa, xa, ac, ec, ecy, sc; logic [15:0] d; bit st, fn;
    lat = -1;
    single_txn(1'b0, 16'h0200, 1'b0, 16'h0000, -1, r, oa, xa, d, ac, ec, ecy, st, sc, fn);
    n_cmp++; if (ec !== 1 || ecy - r !== 15) begin n_bad++; $display("FAIL wdog_err_time: got cnt=%0d at +%0d want 1 at +15", ec, ecy - r); end
    n_cmp++; if (oa !== 1 || ac !== ecy || d !== 16'hFFFF) begin n_bad++; $display("FAIL wdog_ack: got n=%0d dti=%h want 1 ffff", oa, d); end
    n_cmp++; if (sc !== 16 || !fn) begin n_bad++; $display("FAIL wdog_idle: got stb_cycles=%0d fin=%b want 16/1", sc, fn); end
    lat = 15;
    single_txn(1'b0, 16'h0200, 1'b0, 16'h0000, -1, r, oa, xa, d, ac, ec, ecy, st, sc, fn);
    n_cmp++; if (ec !== 0) begin n_bad++; $display("FAIL wdog_edge_err: got %0d want 0", ec); end
    n_cmp++; if (oa !== 1 || ac - r !== 15 || d !== 16'hC15A) begin n_bad++; $display("FAIL wdog_edge_ack: got n=%0d +%0d dti=%h want 1 +15 c15a", oa, ac - r, d); end
  endtask

  task automatic test_drop();
    int r, oa, xa, ac, ec, ecy, sc; logic [15:0] d; bit st, fn;
    lat = 3;
    single_txn(1'b0, 16'h0300, 1'b0, 16'h0000, 2, r, oa, xa, d, ac, ec, ecy, st, sc, fn);
    n_cmp++; if (oa !== 0 || xa !== 0) begin n_bad++; $display("FAIL drop_no_ack: got f=%0d g=%0d want 0/0", oa, xa); end
    n_cmp++; if (sc !== 4 || !fn) begin n_bad++; $display("FAIL drop_stb_persist: got %0d want 4", sc); end
    n_cmp++; if (f_dti !== 16'hC15A) begin n_bad++; $display("FAIL drop_f_dti_hold: got %h want c15a", f_dti); end
    lat = 1;
    single_txn(1'b1, 16'h8300, 1'b0, 16'h0000, -1, r, oa, xa, d, ac, ec, ecy, st, sc, fn);
    n_cmp++; if (r !== 1 || oa !== 1) begin n_bad++; $display("FAIL drop_next_g: got rise=%0d ack=%0d want 1/1", r, oa); end
  endtask

  task automatic test_spurious();
    @(posedge clk); #1 spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({f_ack, g_ack, m_stb} !== 3'b000) begin
        n_bad++; $display("FAIL spurious_ack: got f=%b g=%b stb=%b want 000", f_ack, g_ack, m_stb);
      end
    end
    spur = 1'b0;
    @(negedge clk);
    n_cmp++; if (f_dti !== 16'hC15A) begin n_bad++; $display("FAIL spurious_dti: got %h want c15a", f_dti); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 1;
    run_masters(3, 3, 0);
    n_cmp++;
    if (own_q.size() !== 6) begin
      n_bad++; $display("FAIL tie_count: got %0d want 6", own_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (own_q[i] !== 1'(i % 2)) begin n_bad++; $display("FAIL tie_order[%0d]: got %0d want %0d", i, own_q[i], i % 2); end
      end
      for (int i = 1; i < 6; i++) begin
        n_cmp++;
        if (rise_q[i] - rise_q[i-1] !== 3) begin n_bad++; $display("FAIL tie_spacing[%0d]: got %0d want 3", i, rise_q[i] - rise_q[i-1]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    lat = -1;
    @(posedge clk); #1;
    g_adr = 16'h9000; g_wre = 1'b0; g_dto = 16'h0; g_stb = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (m_stb !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre: got %b want 1", m_stb); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (m_stb !== 1'b0 || g_ack !== 1'b0) begin n_bad++; $display("FAIL rstmid_drop: got stb=%b ack=%b want 0/0", m_stb, g_ack); end
    @(posedge clk); #1;
    n_cmp++; if (g_ack !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_ack: got %b want 0", g_ack); end
    rst = 1'b0; g_stb = 1'b0; lat = 1;
    run_masters(1, 1, 0);
    n_cmp++;
    if (own_q.size() !== 2 || own_q[0] !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_first_f: got n=%0d first=%0d want 2/0", own_q.size(), own_q.size() > 0 ? own_q[0] : 1'b1);
    end
  endtask

  task automatic test_random();
    do_reset();
    rand_lat = 1'b1;
    run_masters(12, 12, 3);
    rand_lat = 1'b0;
    n_cmp++; if (own_q.size() !== 24) begin n_bad++; $display("FAIL random_count: got %0d want 24", own_q.size()); end
  endtask

  initial begin
    rst = 1'b1;
    f_adr = '0; f_stb = 1'b0; f_wre = 1'b0; f_dto = '0;
    g_adr = '0; g_stb = 1'b0; g_wre = 1'b0; g_dto = '0;
    test_reset();
    test_single_read();
    test_g_write();
    test_watchdog();
    test_drop();
    test_spurious();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
